// File: rtl/fp_pkg.sv
// Shared constants and encodings for the float-to-integer converter.
// Field widths follow the adder's packed single-precision format.
package fp_pkg;

  localparam int WIDTH_TOTAL = 32;
  localparam int WIDTH_E     = 8;
  localparam int WIDTH_F     = 23;
  localparam int WIDTH_I     = 32;
  localparam int BIAS        = 127;
  localparam int EXP_MAX     = 255;

  localparam logic [WIDTH_I-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [WIDTH_I-1:0] INT_MIN = 32'h8000_0000;

  // -2^31 is the only e>=158 operand that still fits
  localparam logic [WIDTH_TOTAL-1:0] FA_INT_MIN = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    C_NAN,
    C_INF,
    C_SMALL,
    C_BIG,
    C_NORMAL
  } fclass_t;

endpackage

// File: rtl/fp_to_int_if.sv
// Operand / result handshake bundle for fp_to_int.
// master drives operands and result acceptance; slave is the converter.
interface fp_to_int_if;
  import fp_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH_TOTAL-1:0] fa;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH_I-1:0]     iout;
  logic                   invalid;
  logic                   overflow;
  logic                   inexact;

  modport master (
    output in_valid, fa, out_ready,
    input  in_ready, out_valid, iout,
    input  invalid, overflow, inexact
  );

  modport slave (
    input  in_valid, fa, out_ready,
    output in_ready, out_valid, iout,
    output invalid, overflow, inexact
  );

endinterface

// File: rtl/fp_unpack.sv
// Splits a packed float into fields and classifies it for conversion.
// d is the unbiased shift distance e - (BIAS + WIDTH_F).
module fp_unpack
  import fp_pkg::*;
(
  input  logic [WIDTH_TOTAL-1:0] fa,
  output logic                   s,
  output logic [WIDTH_E-1:0]     e,
  output logic [WIDTH_F-1:0]     f,
  output fclass_t                cls,
  output logic signed [WIDTH_E+1:0] d,
  output logic [WIDTH_E-1:0]     d_abs
);

  localparam logic [WIDTH_E-1:0] E_MAX = WIDTH_E'(EXP_MAX);
  localparam logic [WIDTH_E-1:0] E_ONE = WIDTH_E'(BIAS);
  localparam logic [WIDTH_E-1:0] E_BIG = WIDTH_E'(BIAS + WIDTH_I - 1);
  localparam logic signed [WIDTH_E+1:0] D_OFS =
    $signed((WIDTH_E+2)'(BIAS + WIDTH_F));

  logic is_nan, is_inf, is_small, is_big;

  assign s = fa[WIDTH_TOTAL-1];
  assign e = fa[WIDTH_TOTAL-2 -: WIDTH_E];
  assign f = fa[WIDTH_F-1:0];

  assign d     = $signed({2'b00, e}) - D_OFS;
  assign d_abs = WIDTH_E'(d[WIDTH_E+1] ? -d : d);

  assign is_nan   = (e == E_MAX) && (f != '0);
  assign is_inf   = (e == E_MAX) && (f == '0);
  assign is_small = (e < E_ONE);
  assign is_big   = (e != E_MAX) && (e >= E_BIG);

  always_comb begin
    cls = C_NORMAL;
    unique case (1'b1)
      is_nan:   cls = C_NAN;
      is_inf:   cls = C_INF;
      is_small: cls = C_SMALL;
      is_big:   cls = C_BIG;
      default:  cls = C_NORMAL;
    endcase
  end

endmodule

// File: rtl/fp_to_int.sv
// Iterative float to int32 converter, round toward zero.
// Mantissa moves one bit per cycle; one conversion in flight.
module fp_to_int
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fp_to_int_if.slave  io
);

  state_t state, state_n;

  logic [WIDTH_I-1:0] mag, mag_n;
  logic [WIDTH_I-1:0] iout_q, iout_n;
  logic [WIDTH_E-1:0] cnt, cnt_n;
  logic sgn, sgn_n, left, left_n;
  logic inv_q, inv_n, ovf_q, ovf_n;
  logic inx_q, inx_n;

  logic                s;
  logic [WIDTH_E-1:0]  e;
  logic [WIDTH_F-1:0]  f;
  fclass_t             cls;
  logic signed [WIDTH_E+1:0] d;
  logic [WIDTH_E-1:0]  d_abs;

  fp_unpack u_unpack (
    .fa    (io.fa),
    .s     (s),
    .e     (e),
    .f     (f),
    .cls   (cls),
    .d     (d),
    .d_abs (d_abs)
  );

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.iout      = iout_q;
  assign io.invalid   = inv_q;
  assign io.overflow  = ovf_q;
  assign io.inexact   = inx_q;

  always_comb begin
    state_n = state;
    mag_n   = mag;
    iout_n  = iout_q;
    cnt_n   = cnt;
    sgn_n   = sgn;
    left_n  = left;
    inv_n   = inv_q;
    ovf_n   = ovf_q;
    inx_n   = inx_q;
    unique case (state)
      IDLE: begin
        if (io.in_valid) begin
          sgn_n   = s;
          iout_n  = '0;
          inv_n   = 1'b0;
          ovf_n   = 1'b0;
          inx_n   = 1'b0;
          state_n = DONE;
          unique case (cls)
            C_NAN: begin
              iout_n = INT_MAX;
              inv_n  = 1'b1;
            end
            C_INF: begin
              iout_n = s ? INT_MIN : INT_MAX;
              ovf_n  = 1'b1;
            end
            C_SMALL: begin
              inx_n = (e != '0) || (f != '0);
            end
            C_BIG: begin
              if (io.fa == FA_INT_MIN) begin
                iout_n = INT_MIN;
              end else begin
                iout_n = s ? INT_MIN : INT_MAX;
                ovf_n  = 1'b1;
              end
            end
            default: begin
              mag_n   = {{(WIDTH_I-WIDTH_F-1){1'b0}}, 1'b1, f};
              cnt_n   = d_abs;
              left_n  = (d > 0);
              state_n = SHIFT;
            end
          endcase
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          if (left) begin
            mag_n = mag << 1;
          end else begin
            mag_n = mag >> 1;
            inx_n = inx_q | mag[0];
          end
          cnt_n = cnt - 1'b1;
        end else begin
          iout_n  = sgn ? (~mag + 1'b1) : mag;
          state_n = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mag    <= '0;
      iout_q <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      left   <= 1'b0;
      inv_q  <= 1'b0;
      ovf_q  <= 1'b0;
      inx_q  <= 1'b0;
    end else begin
      state  <= state_n;
      mag    <= mag_n;
      iout_q <= iout_n;
      cnt    <= cnt_n;
      sgn    <= sgn_n;
      left   <= left_n;
      inv_q  <= inv_n;
      ovf_q  <= ovf_n;
      inx_q  <= inx_n;
    end
  end

endmodule

// File: doc/fp_to_int.md
Name: fp_to_int

Overview:
- Iterative converter from IEEE-754 single-precision to a signed 32-bit two's-complement integer.
- Rounds toward zero, which matches the truncating behaviour of the team's FP add/sub datapath.
- Unpacks the packed float format that the adder produces, so FP results can be handed back to integer logic.
- Multi-cycle: a 1-bit-per-cycle barrel-free shifter, with valid/ready handshakes on both sides.

Parameters:
- WIDTH_TOTAL, 32, packed float width.
- WIDTH_E, 8, exponent field width.
- WIDTH_F, 23, fraction field width.
- WIDTH_I, 32, integer output width.
- BIAS, 127, exponent bias.
- Only the defaults are verified. Other values are unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fa is valid.
- in_ready  out  1  converter can accept fa.
- fa  in  32  float operand: {sign, exp[7:0], frac[22:0]}.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- iout  out  32  signed integer result.
- invalid  out  1  operand was NaN.
- overflow  out  1  |value| is not representable (includes ±Inf).
- inexact  out  1  nonzero fraction bits were discarded.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Reset is synchronous and active-high on rst.
  - rst overrides everything, including mid-operation.
  - Next state after rst is IDLE with in_ready=1, out_valid=0, iout=0, invalid=0, overflow=0, inexact=0.
  - Any conversion in flight is discarded.
- States:
  - IDLE: in_ready=1. On in_valid, fa is accepted and fields are captured.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Classification at acceptance (s, e, f = fields of fa; d = e - 150, signed):
  - e=255, f≠0: iout=0x7FFFFFFF, invalid=1 → DONE.
  - e=255, f=0: iout = s ? 0x80000000 : 0x7FFFFFFF, overflow=1 → DONE.
  - e<127 (includes zero and denormals): iout=0, inexact = (e≠0 or f≠0) → DONE.
  - e≥158: if fa=0xCF000000, iout=0x80000000 with no flags. Otherwise saturate as for ±Inf with overflow=1. → DONE.
  - 127≤e≤157: mag = {1, f} zero-extended to 32 bits, cnt = |d| (0..23), dir = (d>0 ? left : right), inexact=0 → SHIFT.
- SHIFT, cnt≠0:
  - Shift mag by 1 in dir, cnt--.
  - On a right shift, inexact |= mag[0] before the shift (sticky).
- SHIFT, cnt=0:
  - iout = s ? (~mag + 1) : mag.
  - → DONE.
- DONE:
  - iout and flags are held stable while out_ready=0.
  - When out_ready=1: → IDLE, out_valid drops next cycle.
  - No new input is accepted in the same cycle as the result handoff.
- Latency, from the accepting edge to the first cycle with out_valid=1:
  - Special and zero paths: 1 cycle.
  - Normal path: |d| + 2 cycles. Worst case is 25 cycles.
- Throughput: one conversion in flight.
- Flags are mutually exclusive except inexact, which is only set on the zero and normal paths.
- While in_ready=0, in_valid and fa are ignored. There is no queuing.

Decomposition:
- Shared package fp_pkg holds the exponent and fraction widths, BIAS, EXP_MAX=255, INT_MAX=0x7FFFFFFF, INT_MIN=0x80000000, and the state encoding enum (IDLE, SHIFT, DONE).
- One sub-module, fp_unpack (combinational):
  - Splits fa into s, e and f.
  - Outputs class (nan / inf / small / big / normal), d, and |d|.
  - Reusable by the adder's future sequential version.

Test Plan:
- fa=0x3F800000 (1.0): d=-23 → iout=1, no flags, out_valid 25 cycles after acceptance. Also fa=0x4B000001 → iout=8388609, exact, latency 2.
- fa=0xC0490FDB (-3.14159) → iout=0xFFFFFFFD, inexact=1. Also fa=0x4EFFFFFF → iout=0x7FFFFF80 (left shift 7), exact.
- fa=0x4F000000 → iout=0x7FFFFFFF, overflow=1. fa=0xCF000000 → iout=0x80000000, no flags. fa=0xFF800000 → iout=0x80000000, overflow=1.
- fa=0x7FC00000 → iout=0x7FFFFFFF, invalid=1, latency 1. fa=0x3F000000 (0.5) → iout=0, inexact=1. fa=0x80000000 → iout=0, no flags.
- Backpressure: result ready with out_ready=0 for 5 cycles → iout and flags stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 → next cycle in_ready=1, out_valid=0.
- Reset mid-SHIFT: accept 0x3F800000, assert rst at cycle 10 → next cycle IDLE, in_ready=1, out_valid=0, all outputs 0, and no stale result afterwards.
